// File: rtl/im_ctrl_pkg.sv
// Shared constants for the IM boot/load controller.
// State codes, IM geometry and word-to-byte address helper.
package im_ctrl_pkg;

  localparam int IM_DEPTH   = 16;
  localparam int IM_AW      = 4;
  localparam int DW         = 32;
  localparam int BYTE_SHIFT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [31:0] word_addr(
    input logic [IM_AW-1:0] p
  );
    return {{(32-IM_AW-BYTE_SHIFT){1'b0}},
            p, {BYTE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/im_cksum_acc.sv
// Running XOR accumulator of loaded words; clr wins over en.
// Ports: clk, reset (async low), clr, en, d -> acc.
module im_cksum_acc
  import im_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] acc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/im_load_ctrl.sv
// Boot loader: streams words into IM, stalls CPU, then hands IM port to PC.
// Ports: loader valid/ready, cpu_pc in, IM port out, status; checksum via IM_LOAD_CHECKSUM_EN.
module im_load_ctrl
  import im_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [4:0]    load_count,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [31:0]   cpu_pc,
  output logic [31:0]   im_pc,
  output logic [DW-1:0] im_dataIn,
  output logic          im_memWrite,
  output logic          im_memRead,
  output logic          cpu_stall,
  output logic          busy,
  output logic          load_done,
  output logic [4:0]    words_loaded,
  input  logic [DW-1:0] exp_checksum,
  output logic          load_err
);

  localparam logic [IM_AW-1:0] PTR_ONE = 1;
  localparam logic [4:0] DEPTH5 = 5'(IM_DEPTH);

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic [4:0]       cnt_sat;
  logic [IM_AW-1:0] wr_ptr;
  logic [31:0]      pc_q;
  logic             start;
  logic             accept;
  logic             last;

  assign cnt_sat = (load_count > DEPTH5) ? DEPTH5
                                         : load_count;
  assign start  = (state == ST_IDLE) && load_start;
  assign accept = in_valid && in_ready;
  assign last   = accept &&
                  ((words_loaded + 5'd1) == cnt);

  assign in_ready    = (state == ST_LOAD);
  assign busy        = (state == ST_LOAD);
  assign cpu_stall   = (state != ST_IDLE);
  assign im_memRead  = (state == ST_IDLE);
  assign load_done   = (state == ST_DONE);
  // Outside IDLE the IM address is the last written word,
  // so the DONE-cycle write still sees its own address.
  assign im_pc = (state == ST_IDLE) ? cpu_pc : pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      pc_q         <= '0;
      im_dataIn    <= '0;
      im_memWrite  <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_memWrite <= accept;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            cnt          <= cnt_sat;
            wr_ptr       <= '0;
            pc_q         <= '0;
            words_loaded <= '0;
            state <= (cnt_sat == 5'd0) ? ST_DONE
                                       : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            im_dataIn    <= in_data;
            pc_q         <= word_addr(wr_ptr);
            wr_ptr       <= wr_ptr + PTR_ONE;
            words_loaded <= words_loaded + 5'd1;
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IM_LOAD_CHECKSUM_EN
  logic [DW-1:0] acc;
  logic [DW-1:0] exp_q;

  im_cksum_acc u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (accept),
    .d     (in_data),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q    <= '0;
      load_err <= 1'b0;
    end else if (start) begin
      exp_q    <= exp_checksum;
      load_err <= 1'b0;
    end else if (state == ST_DONE) begin
      load_err <= (acc != exp_q);
    end
  end
`else
  logic unused_cksum;
  assign unused_cksum = ^{exp_checksum, start};
  assign load_err = 1'b0;
`endif

endmodule

// File: doc/im_load_ctrl.md
Name: im_load_ctrl

Overview:
Boot/load controller for the 16-word register-based instruction memory. It owns the IM port (address, write data, write/read strobes) and streams words from an external loader into consecutive IM locations over a valid/ready handshake. While loading, it stalls the CPU. When loading is finished, it hands the IM address port back to the CPU program counter. It sits between the CPU fetch stage, the boot-source interface and the IM.

Parameters:
IM_DEPTH, 16, number of 32-bit IM words (power of two)
IM_AW, 4, word-address bits = log2(IM_DEPTH); the IM decodes pc[IM_AW+1:2]
DW, 32, data/instruction width

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
load_start  in  1  single-cycle request to begin a load (IDLE only)
load_count  in  5  number of words to load; sampled with load_start
in_valid  in  1  loader word valid
in_data  in  DW  loader word
in_ready  out  1  controller accepts word this cycle
cpu_pc  in  32  CPU fetch address
im_pc  out  32  address to IM
im_dataIn  out  DW  write data to IM
im_memWrite  out  1  IM write strobe
im_memRead  out  1  IM read enable
cpu_stall  out  1  CPU must hold PC/fetch
busy  out  1  load in progress
load_done  out  1  one-cycle pulse at end of load
words_loaded  out  5  words written in the last or current load
exp_checksum  in  DW  expected XOR checksum (optional feature)
load_err  out  1  checksum mismatch flag (optional feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wr_ptr=0, im_memWrite=0, im_dataIn=0, words_loaded=0, load_done=0, load_err=0, in_ready=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - im_pc=cpu_pc (combinational pass-through); im_memRead=1; cpu_stall=0; busy=0; in_ready=0.
  - On load_start=1: latch cnt = min(load_count, IM_DEPTH); wr_ptr=0; words_loaded=0.
  - If cnt=0, go to DONE with no write. Otherwise go to LOAD.
- LOAD:
  - in_ready=1, cpu_stall=1, busy=1, im_memRead=0.
  - im_pc={zeros, wr_ptr, 2'b00} is registered.
  - A word is accepted on a posedge where in_valid && in_ready. At that edge: im_dataIn<=in_data, im_pc<=wr_ptr address, im_memWrite<=1, wr_ptr++, words_loaded++.
  - im_memWrite is high for exactly one cycle per accepted word. The IM commits on the negedge inside that cycle, so write latency is half a cycle after the accepting edge.
  - Cycles with no transfer deassert im_memWrite.
  - When the accepted word is word cnt-1: in_ready falls on the next cycle and the state goes to DONE.
  - load_start during LOAD is ignored.
- DONE (exactly 1 cycle):
  - load_done=1, cpu_stall=1, in_ready=0.
  - im_memWrite for the final word is still high in this cycle; it drops on leaving DONE.
  - Then go to IDLE; the next cycle fetches from cpu_pc.
- words_loaded holds its value until the next load_start.
- wr_ptr wraps at IM_DEPTH, which is unreachable because cnt is saturated at 16.
- Reset mid-LOAD aborts immediately. IM contents already written remain; the IM has its own init reset.

Optional Feature:
IM_LOAD_CHECKSUM_EN
- Defined:
  - exp_checksum is sampled at load_start.
  - A running XOR of all accepted words is kept.
  - In DONE, load_err is set if running XOR != exp_checksum.
  - load_err is held until the next load_start or reset.
- Undefined: no accumulator is built, exp_checksum is ignored, and load_err is tied to 0.

Decomposition:
- Shared package im_ctrl_pkg:
  - state encoding IDLE/LOAD/DONE
  - IM_DEPTH, IM_AW
  - word-to-byte address shift constant 2
- One natural sub-module: im_cksum_acc (XOR accumulator with clear/enable), instantiated only under IM_LOAD_CHECKSUM_EN.

Test Plan:
- Reset then idle: cpu_pc=0x0000000C -> im_pc=0x0000000C, im_memRead=1, cpu_stall=0, im_memWrite=0.
- Load 3 words, in_valid always high, data 0xA0000001/2/3 -> im_memWrite high 3 consecutive cycles at im_pc=0x0, 0x4, 0x8; load_done one cycle later; words_loaded=3; IM words 0..2 read back.
- Loader gaps: in_valid toggles 1,0,1 for count=2 -> only 2 writes, no write in the gap cycle, cpu_stall high throughout.
- load_count=0 -> no im_memWrite; load_done one cycle after start; load_count=20 -> exactly 16 writes (im_pc 0x0..0x3C).
- reset pulled low after 2 of 4 words -> all outputs at reset values immediately; words_loaded=0; IDLE pass-through resumes.
- IM_LOAD_CHECKSUM_EN: words 0x1,0x2,0x4 with exp_checksum=0x7 -> load_err=0; with exp_checksum=0x6 -> load_err=1.
